// File: rtl/count_sequencer.sv
// count_sequencer: debounces the start/stop/up/down buttons into one-cycle commands,
// runs the IDLE/RUN/PAUSE control FSM and the count prescaler for the counter datapath.

module count_sequencer #(
  parameter int unsigned TICK_DIV        = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       Clk100M,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       up,
  input  logic       down,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       tick
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE   = DW'(1);
  localparam logic [DW-1:0] DB_ZERO  = {DW{1'b0}};
  localparam logic [PW-1:0] PSC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PSC_ONE  = PW'(1);
  localparam logic [PW-1:0] PSC_ZERO = {PW{1'b0}};

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  logic [3:0]    raw_s;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    lvl_q;
  logic [3:0]    lvl_d;
  logic [3:0]    lvl_prev_q;
  logic [3:0]    cmd_q;
  logic [DW-1:0] dbc_q [4];
  logic [DW-1:0] dbc_d [4];

  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;
  logic          dir_q;
  logic          dir_d;
  logic          clr_q;
  logic          clr_d;
  logic          en_q;
  logic          tick_q;
  logic          wrap_s;

  assign raw_s  = {down, up, stop, start};
  assign wrap_s = (state_q == ST_RUN) && (psc_q == PSC_MAX);

  // Debounce: count consecutive samples disagreeing with the accepted level.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 4; i++) begin
      dbc_d[i] = DB_ZERO;
      if (sync2_q[i] != lvl_q[i]) begin
        if (dbc_q[i] == DB_MAX) begin
          lvl_d[i] = sync2_q[i];
          dbc_d[i] = DB_ZERO;
        end else begin
          dbc_d[i] = dbc_q[i] + DB_ONE;
        end
      end else begin
        dbc_d[i] = DB_ZERO;
      end
    end
  end

  // Synchronizers, debounce state and rising-edge command registers.
  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      lvl_q      <= 4'b0000;
      lvl_prev_q <= 4'b0000;
      cmd_q      <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        dbc_q[i] <= DB_ZERO;
      end
    end else begin
      sync1_q    <= raw_s;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      cmd_q      <= lvl_q & ~lvl_prev_q;
      for (int i = 0; i < 4; i++) begin
        dbc_q[i] <= dbc_d[i];
      end
    end
  end

  // Control FSM, prescaler and direction next-state; stop outranks start.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    clr_d   = 1'b0;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        psc_d = PSC_ZERO;
        if (cmd_q[BTN_STOP]) begin
          state_d = ST_IDLE;
        end else if (cmd_q[BTN_START]) begin
          state_d = ST_RUN;
          clr_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (wrap_s) begin
          psc_d = PSC_ZERO;
        end else begin
          psc_d = psc_q + PSC_ONE;
        end
        if (cmd_q[BTN_STOP]) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (cmd_q[BTN_STOP]) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
          psc_d   = PSC_ZERO;
        end else if (cmd_q[BTN_START]) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        psc_d   = PSC_ZERO;
      end
    endcase

    if (cmd_q[BTN_UP]) begin
      dir_d = 1'b1;
    end else if (cmd_q[BTN_DOWN]) begin
      dir_d = 1'b0;
    end else begin
      dir_d = dir_q;
    end
  end

  // Control state and registered datapath outputs.
  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      psc_q   <= PSC_ZERO;
      dir_q   <= 1'b1;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      dir_q   <= dir_d;
      clr_q   <= clr_d;
      en_q    <= wrap_s;
      tick_q  <= wrap_s;
    end
  end

  assign state   = state_q;
  assign cnt_en  = en_q;
  assign cnt_dir = dir_q;
  assign cnt_clr = clr_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios plus random button activity, every
// cycle compared against a behavioural model of the button/FSM/prescaler rules.

module tb_count_sequencer;

  localparam int TICK_DIV = 100;
  localparam int DEB      = 4;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSE  = 2;

  logic       Clk100M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       up      = 1'b0;
  logic       down    = 1'b0;
  logic       cnt_en;
  logic       cnt_dir;
  logic       cnt_clr;
  logic       tick;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: raw delay line (h0 newest, h1 oldest), run length of disagreeing samples,
  // accepted level, and a one-cycle command delay.
  bit h0 [4];
  bit h1 [4];
  bit lvl [4];
  bit rose [4];
  bit cmd [4];
  int run [4];
  int m_state;
  int m_phase;
  bit m_tick;
  bit m_clr;
  bit m_dir;

  count_sequencer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .Clk100M (Clk100M),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .up      (up),
    .down    (down),
    .cnt_en  (cnt_en),
    .cnt_dir (cnt_dir),
    .cnt_clr (cnt_clr),
    .state   (state),
    .tick    (tick)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      h0[b] = 1'b0; h1[b] = 1'b0; lvl[b] = 1'b0; rose[b] = 1'b0; cmd[b] = 1'b0; run[b] = 0;
    end
    m_state = S_IDLE; m_phase = 0; m_tick = 1'b0; m_clr = 1'b0; m_dir = 1'b1;
  endtask

  task automatic model_step();
    bit raw [4];
    int nxt;
    raw[0] = start; raw[1] = stop; raw[2] = up; raw[3] = down;
    m_tick = (m_state == S_RUN) && (m_phase == TICK_DIV - 1);
    if (m_state == S_RUN) m_phase = (m_phase + 1) % TICK_DIV;
    nxt = m_state;
    case (m_state)
      S_IDLE:  if (cmd[0] && !cmd[1]) nxt = S_RUN;
      S_RUN:   if (cmd[1]) nxt = S_PAUSE;
      S_PAUSE: if (cmd[1]) nxt = S_IDLE; else if (cmd[0]) nxt = S_RUN;
      default: nxt = S_IDLE;
    endcase
    m_clr = (m_state == S_IDLE && nxt == S_RUN) || (m_state == S_PAUSE && nxt == S_IDLE);
    if (nxt == S_IDLE) m_phase = 0;
    m_state = nxt;
    if (cmd[2]) m_dir = 1'b1;
    else if (cmd[3]) m_dir = 1'b0;
    for (int b = 0; b < 4; b++) begin
      cmd[b]  = rose[b];
      rose[b] = 1'b0;
      if (h1[b] != lvl[b]) begin
        run[b]++;
        if (run[b] == DEB) begin
          lvl[b]  = h1[b];
          run[b]  = 0;
          rose[b] = lvl[b];
        end
      end else begin
        run[b] = 0;
      end
      h1[b] = h0[b];
      h0[b] = raw[b];
    end
  endtask

  task automatic step();
    @(posedge Clk100M);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("state", state, m_state);
    chk("cnt_en", cnt_en, m_tick);
    chk("cnt_clr", cnt_clr, m_clr);
    chk("tick", tick, m_tick);
    chk("cnt_dir", cnt_dir, m_dir);
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  // lat = edges between the first sampling edge and the edge that shows target
  task automatic wait_state(input int target, input int max, output int lat);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (state !== target[1:0] && n < max);
    lat = n - 1;
  endtask

  task automatic wait_en(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (cnt_en !== 1'b1 && n < max);
  endtask

  initial begin
    int lat, n, trans, pulses, bad, gap, hi_left, lo_left;
    logic [1:0] prev;

    model_reset();
    settle(3);
    chk("rst_state", state, 0);
    chk("rst_dir", cnt_dir, 1);
    chk("rst_en", cnt_en, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_tick", tick, 0);
    rst_n = 1'b1;
    settle(5);

    // Start held 20 sampling edges: one transition, one clear, cadence of TICK_DIV
    start = 1'b1;
    wait_state(S_RUN, 30, lat);
    chk("start_latency", lat, 7);
    chk("start_clr", cnt_clr, 1);
    n = 0; trans = 0; pulses = 0; prev = state;
    do begin
      if (n == 12) start = 1'b0;
      step();
      n++;
      if (state !== prev) trans++;
      if (cnt_clr) pulses++;
      prev = state;
    end while (cnt_en !== 1'b1 && n < 150);
    chk("first_en_delay", n, 100);
    chk("start_single_transition", trans, 0);
    chk("start_single_clr", pulses, 0);
    wait_en(150, n);
    chk("en_period", n, 100);

    // Stop so the prescaler freezes at 40, then resume without phase loss
    settle(32);
    stop = 1'b1;
    wait_state(S_PAUSE, 30, lat);
    chk("pause_latency", lat, 7);
    chk("pause_no_clr", cnt_clr, 0);
    pulses = 0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 5) stop = 1'b0;
      step();
      if (cnt_en || cnt_clr) pulses++;
      if (state !== 2'b10) bad++;
    end
    chk("pause_silent", pulses, 0);
    chk("pause_hold", bad, 0);
    start = 1'b1;
    wait_state(S_RUN, 30, lat);
    start = 1'b0;
    chk("resume_latency", lat, 7);
    chk("resume_no_clr", cnt_clr, 0);
    wait_en(150, n);
    chk("resume_first_en", n, 60);
    stop = 1'b1;
    wait_state(S_PAUSE, 30, lat);
    stop = 1'b0;
    settle(20);
    stop = 1'b1;
    wait_state(S_IDLE, 30, lat);
    chk("stop_idle_latency", lat, 7);
    chk("stop_idle_clr", cnt_clr, 1);
    step();
    chk("stop_idle_clr_once", cnt_clr, 0);
    stop = 1'b0;
    settle(20);

    // Short stop glitches in RUN must be rejected
    start = 1'b1;
    wait_state(S_RUN, 30, lat);
    start = 1'b0;
    chk("run2_latency", lat, 7);
    wait_en(150, n);
    chk("run2_first_en", n, 100);
    gap = 0; bad = 0; hi_left = 0; lo_left = 0;
    for (int c = 0; c < 260; c++) begin
      if (c >= 50) begin
        stop = 1'b0;
      end else if (hi_left > 0) begin
        stop = 1'b1; hi_left--;
      end else if (lo_left > 0) begin
        stop = 1'b0; lo_left--;
      end else begin
        stop = 1'b1;
        hi_left = $urandom_range(1, 3) - 1;
        lo_left = $urandom_range(1, 3);
      end
      step();
      gap++;
      if (cnt_en) begin
        chk("bounce_gap", gap, 100);
        gap = 0;
      end
      if (state !== 2'b01) bad++;
    end
    chk("bounce_state", bad, 0);

    // Back to IDLE, then start+stop together: stop wins
    stop = 1'b1; wait_state(S_PAUSE, 30, lat); stop = 1'b0; settle(10);
    stop = 1'b1; wait_state(S_IDLE, 30, lat); stop = 1'b0; settle(10);
    chk("back_to_idle", state, 0);
    start = 1'b1; stop = 1'b1; bad = 0; pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) begin
        start = 1'b0; stop = 1'b0;
      end
      step();
      if (state !== 2'b00) bad++;
      if (cnt_clr) pulses++;
    end
    chk("simul_stays_idle", bad, 0);
    chk("simul_no_clr", pulses, 0);

    // Direction: down alone, then up+down together (up wins)
    start = 1'b1; wait_state(S_RUN, 30, lat); start = 1'b0;
    down = 1'b1; settle(8); down = 1'b0; settle(5);
    chk("down_dir", cnt_dir, 0);
    up = 1'b1; down = 1'b1; settle(8); up = 1'b0; down = 1'b0; settle(5);
    chk("up_down_dir", cnt_dir, 1);

    // Down command timed so cnt_dir falls on the edge that consumes a cnt_en
    wait_en(150, n);
    chk("coinc_sync_en", cnt_en, 1);
    settle(93);
    down = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (cnt_en !== 1'b1 && n < 20);
    chk("coinc_en_at", n, 7);
    chk("coinc_old_dir", cnt_dir, 1);
    step();
    chk("coinc_new_dir", cnt_dir, 0);
    chk("coinc_en_done", cnt_en, 0);
    down = 1'b0;
    wait_en(150, n);
    chk("coinc_next_period", n, 99);
    chk("coinc_next_dir", cnt_dir, 0);

    // Random button activity against the model
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 15) == 0) stop  = ~stop;
      if ($urandom_range(0, 15) == 0) up    = ~up;
      if ($urandom_range(0, 15) == 0) down  = ~down;
      step();
    end
    start = 1'b0; stop = 1'b0; up = 1'b0; down = 1'b0;
    settle(20);

    // Asynchronous reset mid-cycle while running with cnt_dir=0
    rst_n = 1'b0; settle(2); rst_n = 1'b1; settle(3);
    start = 1'b1; wait_state(S_RUN, 30, lat); start = 1'b0;
    down = 1'b1; settle(8); down = 1'b0; settle(120);
    chk("pre_reset_run", state, 1);
    chk("pre_reset_dir", cnt_dir, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_dir", cnt_dir, 1);
    chk("async_rst_en", cnt_en, 0);
    chk("async_rst_clr", cnt_clr, 0);
    chk("async_rst_tick", tick, 0);
    model_reset();
    settle(3);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (cnt_en || cnt_clr || tick) pulses++;
    end
    chk("post_reset_pulses", pulses, 0);
    chk("post_reset_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
